// File: rtl/input_encoder_pkg.sv
// Shared definitions for the rate-coding input encoder: FSM state type and default sizing.
package input_pkg;

  localparam int DEF_INPUT_SIZE  = 16;
  localparam int DEF_VALUE_WIDTH = 8;
  localparam int DEF_NUM_STEPS   = 64;
  localparam int DEF_STEP_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } enc_state_t;

endpackage

// File: rtl/input_encoder_if.sv
// Presentation handshake and spike output bundle between a stimulus source and the encoder.
interface input_encoder_if
  import input_pkg::*;
#(
  parameter int INPUT_SIZE  = DEF_INPUT_SIZE,
  parameter int VALUE_WIDTH = DEF_VALUE_WIDTH
);

  logic                              start;
  logic [INPUT_SIZE*VALUE_WIDTH-1:0] value;
  logic                              ready;
  logic [INPUT_SIZE-1:0]             spike;
  logic                              out_valid;

  modport master (
    output start,
    output value,
    input  ready,
    input  spike,
    input  out_valid
  );

  modport slave (
    input  start,
    input  value,
    output ready,
    output spike,
    output out_valid
  );

endinterface

// File: rtl/input_encoder_rate_channel.sv
// One rate-coded channel: latched intensity, wrapping accumulator, spike on accumulator carry-out.
module rate_channel
  import input_pkg::*;
#(
  parameter int VALUE_WIDTH = DEF_VALUE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   step_en,
  input  logic [VALUE_WIDTH-1:0] value_in,
  output logic                   spike
);

  logic [VALUE_WIDTH-1:0] val_q;
  logic [VALUE_WIDTH-1:0] acc_q;
  logic [VALUE_WIDTH:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, val_q};

  // Loading performs step 1 (0 + value can never carry), so the first spike bit appears the cycle after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
      acc_q <= '0;
      spike <= 1'b0;
    end else if (load) begin
      val_q <= value_in;
      acc_q <= value_in;
      spike <= 1'b0;
    end else if (step_en) begin
      acc_q <= sum[VALUE_WIDTH-1:0];
      spike <= sum[VALUE_WIDTH];
    end else begin
      spike <= 1'b0;
    end
  end

endmodule

// File: rtl/input_encoder.sv
// Rate-coding input encoder: IDLE/RUN/GAP sequencing, step counter and out_valid around
// INPUT_SIZE rate_channel instances.
module input_encoder
  import input_pkg::*;
#(
  parameter int INPUT_SIZE  = DEF_INPUT_SIZE,
  parameter int VALUE_WIDTH = DEF_VALUE_WIDTH,
  parameter int NUM_STEPS   = DEF_NUM_STEPS,
  parameter int STEP_WIDTH  = DEF_STEP_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input_encoder_if.slave bus
);

  localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(NUM_STEPS);
  localparam logic [STEP_WIDTH-1:0] STEP_ONE  = STEP_WIDTH'(1);

  enc_state_t            state_q;
  enc_state_t            state_d;
  logic [1:0]            rst_pipe;
  logic                  rst_int;
  logic                  load;
  logic                  step_en;
  logic                  ready_c;
  logic                  out_valid_q;
  logic [STEP_WIDTH-1:0] step_q;
  logic [INPUT_SIZE-1:0] spike_vec;

  // Reset asserts immediately with rst and releases two clk edges after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_pipe <= 2'b11;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b0};
    end
  end

  assign rst_int = rst_pipe[1];

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step_en = 1'b0;
    ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (step_q == LAST_STEP) begin
          state_d = GAP;
        end else begin
          step_en = 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // step_q counts the step currently on the outputs; load already presents step 1.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      step_q      <= '0;
      out_valid_q <= 1'b0;
    end else if (load) begin
      step_q      <= STEP_ONE;
      out_valid_q <= 1'b1;
    end else if (step_en) begin
      step_q      <= step_q + STEP_ONE;
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_chan
    rate_channel #(
      .VALUE_WIDTH (VALUE_WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst      (rst_int),
      .load     (load),
      .step_en  (step_en),
      .value_in (bus.value[i*VALUE_WIDTH +: VALUE_WIDTH]),
      .spike    (spike_vec[i])
    );
  end

  assign bus.ready     = ready_c;
  assign bus.spike     = spike_vec;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_input_encoder.sv
// Directed/randomized bench for input_encoder; spike expectations come from the floor(k*v/2^W) rule.
module tb_input_encoder;

  localparam int IS = 16;
  localparam int VW = 8;
  localparam int NS = 64;
  localparam int SW = 8;

  typedef logic [VW-1:0] vals_t [IS];

  logic clk;
  logic rst;
  int   checks_total;
  int   checks_passed;

  input_encoder_if #(.INPUT_SIZE(IS), .VALUE_WIDTH(VW)) bus ();

  input_encoder #(
    .INPUT_SIZE  (IS),
    .VALUE_WIDTH (VW),
    .NUM_STEPS   (NS),
    .STEP_WIDTH  (SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IS*VW-1:0] pack_values(input vals_t v);
    logic [IS*VW-1:0] p;
    p = '0;
    for (int i = 0; i < IS; i++) p[i*VW +: VW] = v[i];
    return p;
  endfunction

  // Channel fires at step k when floor(k*v/2^W) steps up from floor((k-1)*v/2^W).
  function automatic logic [IS-1:0] model_spike(input vals_t v, input int k);
    logic [IS-1:0] s;
    for (int i = 0; i < IS; i++)
      s[i] = ((k * int'(v[i])) >> VW) != (((k - 1) * int'(v[i])) >> VW);
    return s;
  endfunction

  function automatic logic [IS*VW-1:0] junk_value();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic applyStimulus(input logic s, input logic [IS*VW-1:0] v);
    bus.start = s;
    bus.value = v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total = checks_total + 1;
    assert (observed === expected) checks_passed = checks_passed + 1;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic check_quiet(input string tag, input logic exp_ready);
    checkOutput({tag, " ready"}, 32'(bus.ready), 32'(exp_ready));
    checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, " spike"}, 32'(bus.spike), 32'd0);
  endtask

  // Entered on the first output cycle of a window; leaves one cycle after the last sampled step.
  task automatic check_window(input vals_t v, input int nsteps, output int counts[IS]);
    logic [IS-1:0] exp_s;
    for (int i = 0; i < IS; i++) counts[i] = 0;
    for (int k = 1; k <= nsteps; k++) begin
      exp_s = model_spike(v, k);
      checkOutput($sformatf("out_valid step %0d", k), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("spike step %0d", k), 32'(bus.spike), 32'(exp_s));
      for (int i = 0; i < IS; i++) counts[i] = counts[i] + int'(bus.spike[i]);
      @(negedge clk);
    end
    if (nsteps == NS) begin
      for (int i = 0; i < IS; i++)
        checkOutput($sformatf("count ch%0d", i), 32'(counts[i]), 32'((NS * int'(v[i])) >> VW));
    end
  endtask

  task automatic check_gap_idle(input string tag);
    check_quiet({tag, " gap"}, 1'b0);
    @(negedge clk);
    check_quiet({tag, " idle"}, 1'b1);
  endtask

  task automatic run_presentation(input string tag, input vals_t v, output int counts[IS]);
    applyStimulus(1'b1, pack_values(v));
    @(negedge clk);
    applyStimulus(1'b0, junk_value());
    check_window(v, NS, counts);
    check_gap_idle(tag);
  endtask

  initial begin
    vals_t v;
    vals_t vb;
    int    counts[IS];
    int    winner;

    checks_total  = 0;
    checks_passed = 0;
    rst = 1'b0;
    applyStimulus(1'b0, '0);
    #2 rst = 1'b1;

    @(negedge clk);
    check_quiet("in reset", 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] idle after reset");
    for (int c = 0; c < 10; c++) begin
      check_quiet($sformatf("idle %0d", c), 1'b1);
      @(negedge clk);
    end

    $display("[TB] all channels 128");
    for (int i = 0; i < IS; i++) v[i] = 8'd128;
    run_presentation("all128", v, counts);

    $display("[TB] 255/0/1/64 pattern");
    for (int i = 0; i < IS; i++) v[i] = 8'd64;
    v[0] = 8'd255;
    v[1] = 8'd0;
    v[2] = 8'd1;
    run_presentation("edge values", v, counts);

    $display("[TB] random presentations");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < IS; i++) v[i] = VW'($urandom_range(0, 255));
      run_presentation($sformatf("random %0d", r), v, counts);
    end

    $display("[TB] start held high");
    for (int i = 0; i < IS; i++) begin
      v[i]  = VW'($urandom_range(0, 255));
      vb[i] = VW'($urandom_range(0, 255));
    end
    applyStimulus(1'b1, pack_values(v));
    @(negedge clk);
    applyStimulus(1'b1, pack_values(vb));
    check_window(v, NS, counts);
    checkOutput("held gap out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("held gap ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    checkOutput("held idle out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("held idle ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    check_window(vb, NS, counts);
    applyStimulus(1'b0, junk_value());
    check_gap_idle("held end");
    @(negedge clk);
    check_quiet("held no restart", 1'b1);

    $display("[TB] reset at step 20");
    for (int i = 0; i < IS; i++) v[i] = VW'($urandom_range(1, 255));
    applyStimulus(1'b1, pack_values(v));
    @(negedge clk);
    applyStimulus(1'b0, junk_value());
    check_window(v, 19, counts);
    #1 rst = 1'b1;
    #1;
    check_quiet("abort", 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("after abort", 1'b1);
    for (int i = 0; i < IS; i++) v[i] = VW'($urandom_range(0, 255));
    run_presentation("fresh", v, counts);

    $display("[TB] winner channel 7");
    for (int i = 0; i < IS; i++) v[i] = 8'd50;
    v[7] = 8'd200;
    run_presentation("winner", v, counts);
    winner = 0;
    for (int i = 1; i < IS; i++) if (counts[i] > counts[winner]) winner = i;
    checkOutput("winner", 32'(winner), 32'd7);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/input_encoder.md
INPUT_ENCODER -- requirements
Module: input_encoder

Interface
REQ-001 Parameter INPUT_SIZE, default 16, number of spike channels / input values.
REQ-002 Parameter VALUE_WIDTH, default 8, bits per input intensity value.
REQ-003 Parameter NUM_STEPS, default 64, timesteps per presentation (1..2^STEP_WIDTH-1).
REQ-004 Parameter STEP_WIDTH, default 8, timestep counter width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-high.
REQ-007 start  input  1  request to begin a presentation; accepted only when ready=1.
REQ-008 value  input  INPUT_SIZE*VALUE_WIDTH  flattened intensities; channel i at bits [i*VALUE_WIDTH +: VALUE_WIDTH]; sampled only on acceptance.
REQ-009 ready  output  1  high in IDLE only.
REQ-010 spike  output  INPUT_SIZE  registered spike vector, one bit per channel.
REQ-011 out_valid  output  1  registered; high for exactly NUM_STEPS consecutive cycles per presentation.

Function
REQ-012 State machine SHALL have states IDLE, RUN, GAP.
REQ-013 IDLE: start=1 -> latch value into per-channel registers, clear accumulators and step counter, go to RUN.
REQ-014 start while ready=0 (RUN or GAP) SHALL be ignored; latched values SHALL NOT change.
REQ-015 RUN, every cycle: acc[i] <= (acc[i] + val[i]) mod 2^VALUE_WIDTH; spike[i] <= carry-out of that sum; out_valid <= 1; step counter increments.
REQ-016 First out_valid=1 cycle SHALL be the cycle after acceptance (latency 1); spike and out_valid SHALL be cycle-aligned.
REQ-017 After the NUM_STEPS-th step, out_valid SHALL deassert and the FSM SHALL enter GAP for exactly one cycle, spike=0.
REQ-018 GAP -> IDLE unconditionally; ready=1 from that cycle; back-to-back presentations therefore have at least one out_valid=0 cycle between windows.
REQ-019 Outside RUN, spike SHALL be all-zero and out_valid SHALL be 0.
REQ-020 Spike count on channel i per presentation SHALL equal floor(NUM_STEPS*val[i]/2^VALUE_WIDTH); step k spikes iff floor(k*v/2^W) > floor((k-1)*v/2^W).
REQ-021 val[i]=0 SHALL never spike; accumulator wrap-around is the sole spike source (no saturation).
REQ-022 Step counter SHALL be STEP_WIDTH bits and SHALL NOT wrap within a presentation.

Reset
REQ-023 rst=1 SHALL immediately force: state IDLE, ready=1, spike=0, out_valid=0, accumulators=0, step counter=0, latched values=0.
REQ-024 rst mid-RUN SHALL abort the presentation with no GAP cycle; first start after rst release SHALL behave as a fresh presentation.
REQ-025 Reset deassertion SHALL be synchronised to clk internally before release of state.

Structure
REQ-026 Shared package input_pkg SHALL hold the state enum (IDLE/RUN/GAP) and default parameter constants.
REQ-027 One sub-module rate_channel (value latch, accumulator, carry-out spike) SHALL be instantiated INPUT_SIZE times by generate.
REQ-028 input_encoder SHALL contain the FSM, step counter and out_valid register only.

Verification
REQ-029 Reset then idle: ready=1, out_valid=0, spike=0 for 10 cycles with start=0.
REQ-030 All channels val=128, NUM_STEPS=64, start one cycle -> out_valid high 64 cycles starting 1 cycle later; each channel spikes on even steps, 32 spikes total.
REQ-031 Channel 0=255, channel 1=0, channel 2=1, others 64 -> counts 63, 0, 0, 16 respectively.
REQ-032 start held high continuously -> start ignored in RUN/GAP; windows of 64 separated by exactly 2 cycles of out_valid=0 (GAP plus IDLE acceptance cycle).
REQ-033 rst asserted at step 20 -> spike and out_valid 0 same cycle; next presentation counts full 64 steps with fresh accumulators.
REQ-034 Loopback: connect spike/out_valid to output_layer; channel 7=200, others 50 -> output_layer reports result=7 with out_valid pulse after window.
